// File: rtl/step_ctrl.sv
// Push-button front end for the up/down counter: synchronizes and debounces two buttons,
// then emits a single-cycle step pulse with a direction level, auto-repeating while held.
module step_ctrl #(
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic step,
    output logic sel,
    output logic busy
);

    localparam int T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int CW    = $clog2(DB_CYCLES + 1);

    localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        STEP = 2'd2,
        WAIT = 2'd3
    } state_t;

    logic [1:0]    raw_s;
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    db_r;
    logic [CW-1:0] cnt_r [2];

    logic          up_p_s;
    logic          dn_p_s;
    logic          release_s;
    logic          opposite_s;

    state_t        state_r;
    state_t        state_next_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_next_s;
    logic          first_r;
    logic          first_next_s;
    logic          sel_r;
    logic          sel_next_s;
    logic          step_r;
    logic          busy_r;

    assign raw_s  = {btn_down, btn_up};
    assign up_p_s = db_r[0];
    assign dn_p_s = db_r[1];

    // Two-flop synchronizers and per-button run-length debounce (bit 0 = up, bit 1 = down)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r  <= 2'b00;
            sync2_r  <= 2'b00;
            db_r     <= 2'b00;
            cnt_r[0] <= {CW{1'b0}};
            cnt_r[1] <= {CW{1'b0}};
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    cnt_r[i] <= {CW{1'b0}};
                end else if (cnt_r[i] == DB_LAST) begin
                    db_r[i]  <= sync2_r[i];
                    cnt_r[i] <= {CW{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CW'(1);
                end
            end
        end
    end

    // A hold ends when its own button is released or the other one joins in
    assign release_s  = sel_r ? ~up_p_s : ~dn_p_s;
    assign opposite_s = sel_r ? dn_p_s : up_p_s;

    // Next-state logic: arm on a lone press, pulse, then wait out the repeat timer
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        first_next_s = first_r;
        sel_next_s   = sel_r;
        case (state_r)
            IDLE: begin
                if (up_p_s ^ dn_p_s) begin
                    sel_next_s   = up_p_s;
                    first_next_s = 1'b1;
                    state_next_s = ARM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ARM: begin
                state_next_s = STEP;
            end
            STEP: begin
                timer_next_s = first_r ? DELAY_LOAD : PERIOD_LOAD;
                first_next_s = 1'b0;
                state_next_s = WAIT;
            end
            WAIT: begin
                if (release_s || opposite_s) begin
                    state_next_s = IDLE;
                end else if (timer_r == {TW{1'b0}}) begin
                    state_next_s = STEP;
                end else begin
                    timer_next_s = timer_r - TW'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, timer and registered outputs; step/busy are loaded from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            timer_r <= {TW{1'b0}};
            first_r <= 1'b0;
            sel_r   <= 1'b1;
            step_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
            first_r <= first_next_s;
            sel_r   <= sel_next_s;
            step_r  <= (state_next_s == STEP);
            busy_r  <= (state_next_s != IDLE);
        end
    end

    assign step = step_r;
    assign sel  = sel_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_step_ctrl.sv
// Self-checking bench for step_ctrl: directed button scenarios plus random holds/bounces,
// compared cycle by cycle against a timeline-based reference model.
module tb_step_ctrl;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic btn_up   = 1'b0;
    logic btn_down = 1'b0;
    logic step;
    logic sel;
    logic busy;

    step_ctrl #(
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .step    (step),
        .sel     (sel),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int e     = 0;

    // Reference model state
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_db [2];
    bit hist_u [$];
    bit hist_d [$];
    bit m_active;
    bit m_sel = 1'b1;
    bit m_step;
    bit m_first;
    int arm_e;
    int last_step;
    int step_at;
    int mdl_count = 0;
    int dut_count = 0;
    int dut_steps [$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, e, obs, exp);
        end
    endtask

    function automatic bit all_differ(input bit h[$], input bit lvl);
        if (h.size() < DB) return 1'b0;
        for (int j = h.size() - DB; j < h.size(); j++)
            if (h[j] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_s1 = '{1'b0, 1'b0};
        m_s2 = '{1'b0, 1'b0};
        m_db = '{1'b0, 1'b0};
        hist_u.delete();
        hist_d.delete();
        m_active  = 1'b0;
        m_sel     = 1'b1;
        m_step    = 1'b0;
        m_first   = 1'b0;
        last_step = -100;
    endtask

    // One clock edge of the model: controller from pre-edge debounced levels, then debounce, then sync
    task automatic model_edge();
        bit up, dn, in_wait;
        up = m_db[0];
        dn = m_db[1];
        m_step = 1'b0;
        if (!m_active) begin
            if (up != dn) begin
                m_active  = 1'b1;
                m_sel     = up;
                arm_e     = e;
                step_at   = e + 1;
                m_first   = 1'b1;
                last_step = -100;
            end
        end else begin
            in_wait = (e != arm_e + 1) && (e != last_step + 1);
            if (in_wait && (m_sel ? (!up || dn) : (!dn || up))) begin
                m_active = 1'b0;
            end else if (e == step_at) begin
                m_step    = 1'b1;
                last_step = e;
                step_at   = e + (m_first ? RD + 1 : RP + 1);
                m_first   = 1'b0;
            end
        end
        if (m_step) mdl_count += m_sel ? 1 : -1;

        hist_u.push_back(m_s2[0]);
        hist_d.push_back(m_s2[1]);
        if (hist_u.size() > DB) void'(hist_u.pop_front());
        if (hist_d.size() > DB) void'(hist_d.pop_front());
        if (all_differ(hist_u, m_db[0])) m_db[0] = !m_db[0];
        if (all_differ(hist_d, m_db[1])) m_db[1] = !m_db[1];

        m_s2 = m_s1;
        m_s1[0] = btn_up;
        m_s1[1] = btn_down;
    endtask

    task automatic cycle(input bit u, input bit d);
        btn_up   = u;
        btn_down = d;
        @(posedge clk);
        e++;
        if (!reset) model_reset();
        else model_edge();
        @(negedge clk);
        chk("step", int'(step), int'(m_step));
        chk("sel", int'(sel), int'(m_sel));
        chk("busy", int'(busy), int'(m_active));
        if (step === 1'b1) begin
            dut_steps.push_back(e);
            dut_count += (sel === 1'b1) ? 1 : -1;
        end
    endtask

    task automatic hold(input bit u, input bit d, input int n);
        for (int i = 0; i < n; i++) cycle(u, d);
    endtask

    initial begin
        int s0, k, n, w, len, lat;
        bit u, d, bounce;

        model_reset();
        hold(1'b0, 1'b0, 3);
        reset = 1'b1;

        // Idle after reset: no steps
        s0 = dut_steps.size();
        hold(1'b0, 1'b0, 50);
        chk("idle_nostep", dut_steps.size() - s0, 0);

        // Fast toggling never survives the debounce
        s0 = dut_steps.size();
        for (int i = 0; i < 30; i++) cycle(((i / 2) % 2) != 0, 1'b0);
        hold(1'b0, 1'b0, 15);
        chk("bounce_nostep", dut_steps.size() - s0, 0);

        // Short up press: one step at k+DB+3
        s0 = dut_steps.size();
        k  = e + 1;
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 20);
        chk("short_count", dut_steps.size() - s0, 1);
        lat = (dut_steps.size() > s0) ? dut_steps[s0] - k : -1;
        chk("short_latency", lat, DB + 3);
        chk("short_counter", dut_count, mdl_count);

        // Long down hold: first repeat after RD+1, later every RP+1
        s0 = dut_steps.size();
        hold(1'b0, 1'b1, 40);
        hold(1'b0, 1'b0, 20);
        n = dut_steps.size() - s0;
        chk("hold_count", n, 9);
        for (int i = 1; i < n; i++)
            chk("hold_gap", dut_steps[s0 + i] - dut_steps[s0 + i - 1], (i == 1) ? RD + 1 : RP + 1);
        chk("hold_counter", dut_count, mdl_count);

        // Both pressed, then up released
        s0 = dut_steps.size();
        hold(1'b1, 1'b1, 20);
        chk("both_nostep", dut_steps.size() - s0, 0);
        hold(1'b0, 1'b1, 30);
        hold(1'b0, 1'b0, 20);
        chk("both_counter", dut_count, mdl_count);

        // Up repeating, down joins, up released
        hold(1'b1, 1'b0, 25);
        hold(1'b1, 1'b1, 15);
        hold(1'b0, 1'b1, 25);
        hold(1'b0, 1'b0, 20);
        chk("switch_counter", dut_count, mdl_count);

        // Async reset while step is high
        w = 0;
        while (step !== 1'b1 && w < 40) begin
            cycle(1'b0, 1'b1);
            w++;
        end
        chk("rst_step_seen", int'(step), 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_step", int'(step), 0);
        chk("rst_sel", int'(sel), 1);
        chk("rst_busy", int'(busy), 0);
        hold(1'b0, 1'b0, 2);
        reset = 1'b1;
        s0 = dut_steps.size();
        hold(1'b0, 1'b0, 50);
        chk("rst_idle_nostep", dut_steps.size() - s0, 0);
        dut_count = 0;
        mdl_count = 0;

        // Random holds with occasional bouncing leading edges
        for (int seg = 0; seg < 60; seg++) begin
            u      = $urandom_range(0, 1) != 0;
            d      = $urandom_range(0, 1) != 0;
            len    = $urandom_range(1, 35);
            bounce = $urandom_range(0, 3) == 0;
            for (int i = 0; i < len; i++) begin
                if (bounce && i < 8) cycle($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
                else cycle(u, d);
            end
        end
        hold(1'b0, 1'b0, 20);
        chk("rand_counter", dut_count, mdl_count);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
